seg7_reader: RTL and testbench



---
 rtl/seg7_pkg.sv | 8 +
 rtl/seg7_encode_inv.sv | 18 +
 rtl/seg7_reader.sv | 90 +++++++++
 tb/tb_seg7_reader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes for hex digits 0..F and reader FSM state encoding
package seg7_pkg;
  localparam logic [15:0][6:0] SEG_CODE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {IDLE, TRACK} state_t;
endpackage

// File: rtl/seg7_encode_inv.sv
// seg7_encode_inv: segment pattern to {valid, hex value} lookup
module seg7_encode_inv
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       valid,
  output logic [3:0] value
);
  always_comb begin
    valid = 1'b0;
    value = 4'd0;
    for (int i = 0; i < 16; i++)
      if (pat == SEG_CODE[i]) begin
        valid = 1'b1;
        value = 4'(i);
      end
  end
endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex digits from a seven-segment bus and classifies each accepted change
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg7,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       new_digit,
  output logic       dir_up,
  output logic       step_err,
  output logic       bad_pattern,
  output logic [7:0] step_count
);
  logic [6:0] s1, s2, prev;
  logic [3:0] cnt, val, digit_n;
  logic       valid, accept, step, valid_n, new_n, up_n, err_n, bad_n;
  logic [7:0] count_n;
  state_t     state, state_n;
  seg7_encode_inv u_enc (.pat(s2), .valid(valid), .value(val));
  // fires on the edge where the stability counter reaches STABLE_CYCLES-1
  assign accept = (s2 == prev) && (cnt == 4'(STABLE_CYCLES - 2));
  always_comb begin
    state_n = state;
    digit_n = digit;
    valid_n = digit_valid;
    new_n   = 1'b0;
    err_n   = 1'b0;
    bad_n   = 1'b0;
    up_n    = dir_up;
    step    = 1'b0;
    if (accept) begin
      if (!valid) begin
        bad_n   = 1'b1;
        valid_n = 1'b0;
        state_n = IDLE;
      end else if (state == IDLE) begin
        digit_n = val;
        valid_n = 1'b1;
        new_n   = 1'b1;
        state_n = TRACK;
      end else if (val != digit) begin
        digit_n = val;
        new_n   = 1'b1;
        if (val == digit + 4'd1) begin
          up_n = 1'b1;
          step = 1'b1;
        end else if (val == digit - 4'd1) begin
          up_n = 1'b0;
          step = 1'b1;
        end else
          err_n = 1'b1;
      end
    end
    count_n = (step && step_count != 8'hFF) ? step_count + 8'd1 : step_count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      prev        <= '0;
      cnt         <= '0;
      state       <= IDLE;
      digit       <= '0;
      digit_valid <= 1'b0;
      new_digit   <= 1'b0;
      dir_up      <= 1'b1;
      step_err    <= 1'b0;
      bad_pattern <= 1'b0;
      step_count  <= '0;
    end else begin
      s1          <= seg7;
      s2          <= ACTIVE_LOW ? ~s1 : s1;
      prev        <= s2;
      cnt         <= (s2 != prev) ? 4'd0 : (cnt == 4'hF ? cnt : cnt + 4'd1);
      state       <= state_n;
      digit       <= digit_n;
      digit_valid <= valid_n;
      new_digit   <= new_n;
      dir_up      <= up_n;
      step_err    <= err_n;
      bad_pattern <= bad_n;
      step_count  <= count_n;
    end
  end
endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: randomized self-check of seg7_reader (active-high and active-low instances)
module tb_seg7_reader;
  localparam int S = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] seg7 = 7'h00, seg7_n;
  logic [3:0] digit_a, digit_b;
  logic valid_a, valid_b, new_a, new_b, up_a, up_b, err_a, err_b, bad_a, bad_b;
  logic [7:0] count_a, count_b;
  int passed = 0, total = 0;
  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int md = 0, mcnt = 0;
  bit mv = 0, mdir = 1;
  logic [6:0] cur = 7'h00;
  assign seg7_n = ~seg7;
  always #5 clk = ~clk;
  seg7_reader #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .seg7(seg7), .digit(digit_a), .digit_valid(valid_a),
    .new_digit(new_a), .dir_up(up_a), .step_err(err_a), .bad_pattern(bad_a), .step_count(count_a));
  seg7_reader #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .seg7(seg7_n), .digit(digit_b), .digit_valid(valid_b),
    .new_digit(new_b), .dir_up(up_b), .step_err(err_b), .bad_pattern(bad_b), .step_count(count_b));
  // drives pat for n cycles; reports first pulse cycle, pulse count, OR of pulses, final outputs
  task automatic hold(input logic [6:0] pat, input int n, output logic [32:0] oa, output logic [32:0] ob);
    logic [7:0] ata = 0, atb = 0, na = 0, nb = 0;
    logic [2:0] pa = 0, pb = 0;
    seg7 = pat;
    cur = pat;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if ({new_a, err_a, bad_a} != 0) begin
        if (ata == 0) ata = 8'(i);
        na++;
        pa |= {new_a, err_a, bad_a};
      end
      if ({new_b, err_b, bad_b} != 0) begin
        if (atb == 0) atb = 8'(i);
        nb++;
        pb |= {new_b, err_b, bad_b};
      end
    end
    oa = {ata, na, pa, digit_a, valid_a, up_a, count_a};
    ob = {atb, nb, pb, digit_b, valid_b, up_b, count_b};
  endtask
  task automatic model(input logic [6:0] pat, input bit acc, output logic [32:0] e);
    logic [2:0] p = 0;
    int v = -1, d;
    if (acc) begin
      for (int i = 0; i < 16; i++) if (pat == codes[i]) v = i;
      if (v < 0) begin
        p = 3'b001;
        mv = 0;
      end else if (!mv) begin
        md = v;
        mv = 1;
        p = 3'b100;
      end else begin
        d = (v - md + 16) % 16;
        if (d != 0) begin
          md = v;
          p = (d == 1 || d == 15) ? 3'b100 : 3'b110;
          if (d == 1 || d == 15) begin
            mdir = (d == 1);
            mcnt = (mcnt < 255) ? mcnt + 1 : 255;
          end
        end
      end
    end
    e = {(p != 0) ? 8'(S + 2) : 8'd0, (p != 0) ? 8'd1 : 8'd0, p, 4'(md), mv, mdir, 8'(mcnt)};
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({digit_a, valid_a, new_a, up_a, err_a, bad_a, count_a, digit_b, valid_b, new_b, up_b, err_b, bad_b, count_b}
        !== {4'd0, 5'b00100, 8'd0, 4'd0, 5'b00100, 8'd0})
      $display("FAIL reset got a=%h/%b b=%h/%b required digit 0 valid 0 dir 1 count 0",
               digit_a, {valid_a, new_a, up_a, err_a, bad_a}, digit_b, {valid_b, new_b, up_b, err_b, bad_b});
    else passed++;
    rst = 1'b0;
  endtask
  task automatic test_sequence(input string name, input logic [6:0] pats [], input int lens []);
    logic [32:0] oa, ob, e;
    foreach (pats[i]) begin
      hold(pats[i], lens[i], oa, ob);
      model(pats[i], lens[i] >= S + 2, e);
      total++;
      if ({oa, ob} !== {e, e})
        $display("FAIL %s step %0d pat=%h got a=%h b=%h required %h", name, i, pats[i], oa, ob, e);
      else passed++;
    end
  endtask
  task automatic test_random(input int iters);
    logic [32:0] oa, ob, e;
    logic [6:0] p;
    int k, n;
    for (int it = 0; it < iters; it++) begin
      k = $urandom_range(0, 4);
      n = S + 3 + $urandom_range(0, 4);
      if (k == 0) p = codes[(md + 1) % 16];
      else if (k == 1) p = codes[(md + 15) % 16];
      else if (k == 2) p = codes[(md + 2 + $urandom_range(0, 12)) % 16];
      else begin
        p = 7'(($urandom_range(0, 127)));
        while (p == cur || (k == 3 && (p inside {codes}))) p = 7'($urandom_range(0, 127));
      end
      if (k == 4) begin
        hold(p, $urandom_range(1, S - 1), oa, ob);
        model(p, 0, e);
        total++;
        if ({oa, ob} !== {e, e}) $display("FAIL random_glitch %0d pat=%h got a=%h b=%h required %h", it, p, oa, ob, e);
        else passed++;
        p = codes[md];
        if (!mv) p = 7'h00;
        if (p == cur) p = codes[(md + 1) % 16];
      end
      hold(p, n, oa, ob);
      model(p, 1, e);
      total++;
      if ({oa, ob} !== {e, e}) $display("FAIL random %0d kind %0d pat=%h got a=%h b=%h required %h", it, k, p, oa, ob, e);
      else passed++;
    end
  endtask
  task automatic test_saturation();
    logic [32:0] oa, ob, e;
    logic [6:0] p;
    for (int it = 0; it < 260; it++) begin
      p = codes[(md + 1) % 16];
      hold(p, S + 3, oa, ob);
      model(p, 1, e);
      total++;
      if ({oa, ob} !== {e, e}) $display("FAIL saturation %0d got a=%h b=%h required %h", it, oa, ob, e);
      else passed++;
    end
    total++;
    if (count_a !== 8'd255 || count_b !== 8'd255)
      $display("FAIL saturation_count got a=%0d b=%0d required 255", count_a, count_b);
    else passed++;
  endtask
  task automatic test_reset_mid();
    logic [32:0] oa, ob, e;
    logic [6:0] p = codes[(md + 1) % 16];
    seg7 = p;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({digit_a, valid_a, new_a, up_a, err_a, bad_a, count_a, digit_b, valid_b, new_b, up_b, err_b, bad_b, count_b}
        !== {4'd0, 5'b00100, 8'd0, 4'd0, 5'b00100, 8'd0})
      $display("FAIL reset_mid got a=%h/%b/%0d b=%h/%b/%0d required digit 0 flags 00100 count 0",
               digit_a, {valid_a, new_a, up_a, err_a, bad_a}, count_a, digit_b, {valid_b, new_b, up_b, err_b, bad_b}, count_b);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    md = 0; mv = 0; mdir = 1; mcnt = 0;
    hold(p, 10, oa, ob);
    model(p, 1, e);
    total++;
    if ({oa, ob} !== {e, e}) $display("FAIL reset_reaccept got a=%h b=%h required %h", oa, ob, e);
    else passed++;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_sequence("count_up", '{7'h3F, 7'h06, 7'h5B}, '{10, 10, 10});
    test_sequence("wrap", '{7'h71, 7'h3F, 7'h71}, '{10, 10, 10});
    test_sequence("jump_glitch", '{7'h06, 7'h66, 7'h00, 7'h66}, '{10, 10, 2, 10});
    test_sequence("invalid", '{7'h00, 7'h6D, 7'h06}, '{10, 10, 10});
    test_random(60);
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
